// File: rtl/uart_tx_frame_seq.sv
// UART transmit frame sequencer: start bit, DATA_WIDTH data bits (LSB first),
// optional parity, one or two stop bits. Bit periods end on BAUD_EN strobes.
module uart_tx_frame_seq #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  BAUD_EN,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    localparam int unsigned           CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0]      LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    par_en_q, par_en_d;
    logic                    stop2_q, stop2_d;
    logic                    par_q, par_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic                    accept;
    logic                    frame_end;

    // State, datapath and registered line outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            par_en_q <= 1'b0;
            stop2_q  <= 1'b0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            par_en_q <= par_en_d;
            stop2_q  <= stop2_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state, serializer and output selection from the upcoming state.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        par_en_d  = par_en_q;
        stop2_d   = stop2_q;
        par_d     = par_q;
        accept    = 1'b0;
        frame_end = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (DATA_VALID) accept = 1'b1;
            end
            S_START: begin
                if (BAUD_EN) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
            end
            S_DATA: begin
                if (BAUD_EN) begin
                    shift_d = shift_q >> 1;
                    if (cnt_q == LAST_BIT) begin
                        state_d = par_en_q ? S_PARITY : S_STOP1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (BAUD_EN) state_d = S_STOP1;
            end
            S_STOP1: begin
                if (BAUD_EN) begin
                    if (stop2_q) state_d = S_STOP2;
                    else         frame_end = 1'b1;
                end
            end
            S_STOP2: begin
                if (BAUD_EN) frame_end = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (frame_end) begin
            if (DATA_VALID) accept = 1'b1;
            else            state_d = S_IDLE;
        end

        // Parity is taken from the word at the moment it is latched, since the
        // shift register no longer holds the whole word once serializing starts.
        if (accept) begin
            state_d  = S_START;
            shift_d  = P_DATA;
            cnt_d    = '0;
            par_en_d = PAR_EN;
            stop2_d  = STOP2;
            par_d    = (^P_DATA) ^ PAR_TYP;
        end

        busy_d = (state_d != S_IDLE);

        case (state_d)
            S_IDLE:   tx_d = 1'b1;
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            S_STOP1:  tx_d = 1'b1;
            S_STOP2:  tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
    end

    assign TX_OUT = tx_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame_seq.sv
// Self-checking bench for uart_tx_frame_seq (8-bit and 5-bit instances).
module tb_uart_tx_frame_seq;

    logic       CLK = 1'b0;
    logic       RST;
    logic       BAUD_EN;
    logic [7:0] pd;
    logic       dv8, dv5;
    logic       PAR_EN, PAR_TYP, STOP2;
    logic       tx8, busy8, tx5, busy5;

    int unsigned ntests = 0;
    int unsigned nfail  = 0;

    always #5 CLK = ~CLK;

    uart_tx_frame_seq #(.DATA_WIDTH(8)) dut8 (
        .CLK(CLK), .RST(RST), .BAUD_EN(BAUD_EN), .P_DATA(pd),
        .DATA_VALID(dv8), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
        .TX_OUT(tx8), .BUSY(busy8)
    );

    uart_tx_frame_seq #(.DATA_WIDTH(5)) dut5 (
        .CLK(CLK), .RST(RST), .BAUD_EN(BAUD_EN), .P_DATA(pd[4:0]),
        .DATA_VALID(dv5), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
        .TX_OUT(tx5), .BUSY(busy5)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line = list of bit values; index advances on each strobed edge
    // after the acceptance edge. Two words are sent back-to-back when nw == 2.
    task automatic send(input bit sel, input logic [7:0] w0, input logic [7:0] w1,
                        input int unsigned nw, input logic pe, input logic pt,
                        input logic s2, input int unsigned period, input bit toggle,
                        input string tag);
        logic        exp_q[$];
        logic [7:0]  w;
        logic        p;
        int unsigned dw, len1, idx, ph, cyc;
        bit          b;
        dw   = sel ? 5 : 8;
        len1 = 0;
        for (int unsigned f = 0; f < nw; f++) begin
            w = (f == 0) ? w0 : w1;
            exp_q.push_back(1'b0);
            p = pt;
            for (int unsigned i = 0; i < dw; i++) begin
                exp_q.push_back(w[i]);
                p = p ^ w[i];
            end
            if (pe) exp_q.push_back(p);
            exp_q.push_back(1'b1);
            if (s2) exp_q.push_back(1'b1);
            if (f == 0) len1 = exp_q.size();
        end

        @(negedge CLK);
        pd = w0; PAR_EN = pe; PAR_TYP = pt; STOP2 = s2;
        dv8 = !sel; dv5 = sel;
        BAUD_EN = 1'($urandom % 2);
        @(posedge CLK);
        idx = 0;
        ph  = $urandom_range(period - 1, 0);
        cyc = 0;
        while (idx < exp_q.size() && cyc < 2000) begin
            @(negedge CLK);
            if (nw == 2 && idx < len1) begin
                dv8 = !sel; dv5 = sel; pd = w1;
            end else begin
                dv8 = 1'b0; dv5 = 1'b0;
            end
            check({tag, "_tx"},   sel ? tx5 : tx8, exp_q[idx]);
            check({tag, "_busy"}, sel ? busy5 : busy8, 1'b1);
            b = ((ph % period) == period - 1);
            BAUD_EN = b;
            ph++;
            if (toggle) begin
                pd = 8'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom); STOP2 = 1'($urandom);
            end
            @(posedge CLK);
            if (b) idx++;
            cyc++;
        end
        check({tag, "_timeout"}, idx, exp_q.size());
        @(negedge CLK);
        dv8 = 1'b0; dv5 = 1'b0; BAUD_EN = 1'b0;
        check({tag, "_idle_tx"},   sel ? tx5 : tx8, 1'b1);
        check({tag, "_idle_busy"}, sel ? busy5 : busy8, 1'b0);
    endtask

    initial begin
        RST = 1'b1; BAUD_EN = 1'b0; pd = '0; dv8 = 1'b0; dv5 = 1'b0;
        PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_tx8", tx8, 1'b1);
        check("rst_busy8", busy8, 1'b0);
        check("rst_tx5", tx5, 1'b1);
        check("rst_busy5", busy5, 1'b0);
        RST = 1'b0;

        // Directed frames
        send(1'b0, 8'hA5, 8'h00, 1, 1'b1, 1'b0, 1'b0, 1, 1'b0, "a5_even");
        send(1'b0, 8'h01, 8'h00, 1, 1'b1, 1'b1, 1'b0, 1, 1'b0, "01_odd");
        send(1'b0, 8'h01, 8'h00, 1, 1'b1, 1'b0, 1'b0, 1, 1'b0, "01_even");
        send(1'b0, 8'h01, 8'h00, 1, 1'b0, 1'b0, 1'b1, 1, 1'b0, "01_stop2");
        send(1'b0, 8'hFF, 8'h00, 1, 1'b0, 1'b0, 1'b0, 4, 1'b1, "ff_baud4_tgl");
        send(1'b0, 8'h3C, 8'hC3, 2, 1'b0, 1'b0, 1'b0, 1, 1'b0, "b2b");
        send(1'b0, 8'h3C, 8'hC3, 2, 1'b1, 1'b1, 1'b1, 3, 1'b0, "b2b_slow");

        // Reset during DATA of an 8'h00 frame
        @(negedge CLK);
        pd = 8'h00; PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0; dv8 = 1'b1; BAUD_EN = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        dv8 = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("midrst_pre_busy", busy8, 1'b1);
        check("midrst_pre_tx", tx8, 1'b0);
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        check("midrst_tx", tx8, 1'b1);
        check("midrst_busy", busy8, 1'b0);
        @(posedge CLK);
        @(negedge CLK);
        check("midrst_hold_tx", tx8, 1'b1);
        check("midrst_hold_busy", busy8, 1'b0);
        send(1'b0, 8'h5A, 8'h00, 1, 1'b1, 1'b1, 1'b1, 1, 1'b0, "post_rst");

        // 5-bit instance
        send(1'b1, 8'h16, 8'h00, 1, 1'b1, 1'b0, 1'b0, 1, 1'b0, "dw5_16");

        // Randomized frames
        for (int r = 0; r < 16; r++) begin
            bit          rsel, rtgl;
            int unsigned rnw;
            rsel = 1'($urandom);
            rnw  = $urandom_range(2, 1);
            rtgl = (rnw == 1) ? 1'($urandom) : 1'b0;
            send(rsel, 8'($urandom), 8'($urandom), rnw, 1'($urandom), 1'($urandom),
                 1'($urandom), $urandom_range(5, 1), rtgl, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
